shift_align_param: RTL and testbench
====================================

Name: shift_align_param

Overview:
- Parametrised successor to the fixed 16-lane/16-bit shift aligner: selects the one candidate bit-shift lane carrying a recurring sync word and forwards it as the aligned stream.
- Adds generic lane count/width/pattern, gap-based loss-of-lock with hysteresis, stale-candidate aging, software re-search request and status outputs.
- Sits between the deserialiser's shifted-copy generator and the frame decoder.

Parameters:
- NUM_LANES, 16, number of candidate shifted lanes (2..32)
- DATA_W, 16, word width per lane
- SYNC_PATTERN, 16'h817E, sync word (DATA_W bits)
- LOCK_LEVEL, 16, valid sync words on one lane required to lock
- MAX_GAP, 64, max consecutive valid non-sync words between syncs before a gap violation
- UNLOCK_LEVEL, 4, consecutive gap violations on the locked lane that drop lock
- CNT_W, 7, counter width; must hold max(LOCK_LEVEL, MAX_GAP, UNLOCK_LEVEL)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  NUM_LANES  per-lane word valid
- datain  in  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- force_search  in  1  sync pulse: drop lock, restart search
- valid  out  1  aligned word valid
- dataout  out  DATA_W  aligned word
- locked  out  1  lock status
- lane_sel  out  $clog2(NUM_LANES)  selected lane index (0 when unlocked)
- sync_err  out  1  one-cycle pulse per gap violation while locked

Behaviour:
- Reset: state SEARCH; all counters 0; valid=0, dataout=0, locked=0, lane_sel=0, sync_err=0; input pipeline registers 0.
- Datapath: datain/valid_in registered every cycle (1 stage); valid/dataout = registered word of lane_sel when locked, else 0/0. Latency datain->dataout = 1 clk.
- Sync word: valid_in[i]=1 and lane word == SYNC_PATTERN.
- Per-lane state: sync_cnt[i], gap_cnt[i]; sync word -> gap_cnt=0; valid non-sync -> gap_cnt+1; invalid -> hold.
- SEARCH:
  - sync word -> sync_cnt[i]+1 (saturating).
  - gap_cnt[i] would exceed MAX_GAP -> sync_cnt[i]=0, gap_cnt[i]=0 (stale candidate).
  - Lane whose sync_cnt reaches LOCK_LEVEL this cycle wins; ties -> lowest index.
  - Next cycle: state LOCKED, locked=1, lane_sel=winner, all sync_cnt/gap_cnt cleared, miss_cnt=0.
- LOCKED (only lane_sel monitored; other lanes' counters held at 0):
  - sync word -> gap_cnt=0, miss_cnt=0.
  - gap_cnt would exceed MAX_GAP -> sync_err pulse, gap_cnt=0, miss_cnt+1.
  - miss_cnt reaches UNLOCK_LEVEL -> next cycle SEARCH, locked=0, lane_sel=0, valid=0, all counters 0.
  - Sync word and violation cannot coincide (exclusive by definition).
- force_search: any state -> SEARCH with all counters cleared next cycle; has priority over a same-cycle lock decision.
- Async rst mid-operation returns everything to reset values immediately.
- Counters saturate, never wrap.

Decomposition:
- Package shift_align_pkg: state enum (SEARCH, LOCKED), default SYNC_PATTERN constant, lane index width function.
- Sub-module sync_lane_cnt (one instance per lane): sync/gap counters, clear input, outputs reach_lock and gap_violation. Top holds FSM, priority encoder, miss_cnt, output mux.

Test Plan:
- Lane 5 sends 16 syncs every 8 words, other lanes noise -> locked=1 one clk after 16th sync, lane_sel=5, dataout follows lane 5 with 1-clk latency.
- Lanes 3 and 9 reach 16th sync same cycle -> lane_sel=3.
- Locked on lane 5, syncs stop, valid words continue -> sync_err pulses every 65 valid words; after 4th, locked=0, valid=0, lane_sel=0.
- Lane 2 gets 10 syncs then 70 valid non-sync words, then 16 syncs -> lock only after the later 16 (counter aged out).
- force_search while locked on lane 7 -> locked=0 next clk; relock after 16 fresh syncs.
- rst asserted mid-search with sync_cnt=12 -> all outputs 0 immediately; 16 new syncs required to lock.

Source files
------------

// File: rtl/shift_align_pkg.sv
// Shared types and helpers for the parametrised shift aligner.
package shift_align_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [15:0] SYNC_PATTERN_DEFAULT = 16'h817E;

  // Width of a lane index; a single-lane build still needs a 1-bit select.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_align_param_lane.sv
// Per-lane sync/gap bookkeeping: counts sync words and the spacing between them.
module sync_lane_cnt
  import shift_align_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int                LOCK_LEVEL   = 16,
  parameter int                MAX_GAP      = 64,
  parameter int                CNT_W        = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clear_i,
  input  logic              locked_mode_i,
  output logic              sync_hit_o,
  output logic              reach_lock_o,
  output logic              gap_violation_o
);

  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  assign sync_hit_o      = valid_i && (data_i == SYNC_PATTERN);
  assign gap_violation_o = valid_i && !sync_hit_o && (gap_cnt_q >= CNT_W'(MAX_GAP));
  assign reach_lock_o    = !locked_mode_i && sync_hit_o
                           && (sync_cnt_q >= CNT_W'(LOCK_LEVEL - 1));

  // While locked only the gap spacing matters, so the sync count stays parked at 0.
  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    sync_cnt_d = sync_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (clear_i) begin
      sync_cnt_d = '0;
      gap_cnt_d  = '0;
    end else if (sync_hit_o) begin
      gap_cnt_d = '0;
      if (!locked_mode_i && (sync_cnt_q != '1)) sync_cnt_d = sync_cnt_q + 1'b1;
    end else if (gap_violation_o) begin
      gap_cnt_d = '0;
      if (!locked_mode_i) sync_cnt_d = '0;
    end else if (valid_i && (gap_cnt_q != '1)) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      sync_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: rtl/shift_align_param.sv
// Picks the shifted lane carrying a recurring sync word and forwards it, with
// gap-based loss of lock, software re-search and status outputs.
module shift_align_param
  import shift_align_pkg::*;
#(
  parameter int                NUM_LANES    = 16,
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int                LOCK_LEVEL   = 16,
  parameter int                MAX_GAP      = 64,
  parameter int                UNLOCK_LEVEL = 4,
  parameter int                CNT_W        = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          valid_in,
  input  logic [NUM_LANES*DATA_W-1:0]   datain,
  input  logic                          force_search,
  output logic                          valid,
  output logic [DATA_W-1:0]             dataout,
  output logic                          locked,
  output logic [lane_w(NUM_LANES)-1:0]  lane_sel,
  output logic                          sync_err
);

  localparam int LW = lane_w(NUM_LANES);

  logic [NUM_LANES-1:0]        vld_q;
  logic [NUM_LANES*DATA_W-1:0] data_q;

  state_e           state_q;
  logic [LW-1:0]    lane_sel_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic             sync_err_q;

  logic [NUM_LANES-1:0] sync_hit, reach, gap_viol;
  logic                 win_found;
  logic [LW-1:0]        win_idx;
  logic                 lock_evt, unlock_evt, clear_all;
  logic                 sel_sync, sel_viol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= valid_in;
      data_q <= datain;
    end
  end

  // Every transition clears all lanes so the new state starts from a clean slate.
  assign sel_sync   = sync_hit[lane_sel_q];
  assign sel_viol   = gap_viol[lane_sel_q];
  assign lock_evt   = (state_q == SEARCH) && win_found;
  assign unlock_evt = (state_q == LOCKED) && sel_viol
                      && (miss_cnt_q >= CNT_W'(UNLOCK_LEVEL - 1));
  assign clear_all  = force_search || lock_evt || unlock_evt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sync_lane_cnt #(
      .DATA_W       (DATA_W),
      .SYNC_PATTERN (SYNC_PATTERN),
      .LOCK_LEVEL   (LOCK_LEVEL),
      .MAX_GAP      (MAX_GAP),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .clk             (clk),
      .rst             (rst),
      .valid_i         (vld_q[i]),
      .data_i          (data_q[i*DATA_W +: DATA_W]),
      .clear_i         (clear_all || ((state_q == LOCKED) && (lane_sel_q != LW'(i)))),
      .locked_mode_i   (state_q == LOCKED),
      .sync_hit_o      (sync_hit[i]),
      .reach_lock_o    (reach[i]),
      .gap_violation_o (gap_viol[i])
    );
  end

  // Scan from the top so the lowest reaching lane is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (reach[i]) begin
        win_found = 1'b1;
        win_idx   = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      lane_sel_q <= '0;
      miss_cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      if (force_search) begin
        state_q    <= SEARCH;
        lane_sel_q <= '0;
        miss_cnt_q <= '0;
      end else begin
        case (state_q)
          SEARCH: begin
            if (win_found) begin
              state_q    <= LOCKED;
              lane_sel_q <= win_idx;
              miss_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (sel_sync) begin
              miss_cnt_q <= '0;
            end else if (sel_viol) begin
              sync_err_q <= 1'b1;
              if (unlock_evt) begin
                state_q    <= SEARCH;
                lane_sel_q <= '0;
                miss_cnt_q <= '0;
              end else begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign locked   = (state_q == LOCKED);
  assign lane_sel = lane_sel_q;
  assign sync_err = sync_err_q;
  assign valid    = locked && vld_q[lane_sel_q];
  assign dataout  = locked ? data_q[lane_sel_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_shift_align_param.sv
// Directed bench for shift_align_param: lock, tie-break, gap unlock, aging, force and reset.
module tb_shift_align_param;

  localparam int NL = 16;
  localparam int DW = 16;
  localparam logic [DW-1:0] PAT = 16'h817E;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NL-1:0]        valid_in;
  logic [NL*DW-1:0]     datain;
  logic                 force_search;
  logic                 valid;
  logic [DW-1:0]        dataout;
  logic                 locked;
  logic [3:0]           lane_sel;
  logic                 sync_err;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [DW-1:0] last_word [NL];

  always #5 clk = ~clk;

  shift_align_param dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .datain       (datain),
    .force_search (force_search),
    .valid        (valid),
    .dataout      (dataout),
    .locked       (locked),
    .lane_sel     (lane_sel),
    .sync_err     (sync_err)
  );

  // One clock of traffic: masked lanes carry the sync word, the rest carry
  // noise whose top nibble is 0 so it can never match the pattern.
  task automatic cycle(input logic [NL-1:0] sync_mask);
    logic [DW-1:0] w;
    logic [7:0]    c;
    c = cyc_cnt[7:0];
    for (int i = 0; i < NL; i++) begin
      w = sync_mask[i] ? PAT : {4'h0, 4'(i), c};
      last_word[i] = w;
      datain[i*DW +: DW] = w;
    end
    valid_in = '1;
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  // n periods of: one sync word on masked lanes followed by 7 noise words.
  task automatic send_syncs(input logic [NL-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      cycle(mask);
      for (int m = 0; m < 7; m++) cycle('0);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    force_search = 1'b0;
    valid_in = '0;
    datain = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    force_search = 1'b0;
    valid_in = '1;
    datain = {NL{PAT}};
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (dataout !== '0)    begin errors++; $display("FAIL reset_dataout got=%h exp=0000", dataout); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (lane_sel !== 4'd0) begin errors++; $display("FAIL reset_lane_sel got=%0d exp=0", lane_sel); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
    rst = 1'b0;
    valid_in = '0;
    datain = '0;
    @(posedge clk);
    #1;
  endtask

  // Lock on lane 5; leaves two post-sync noise words already sent.
  task automatic test_lock_lane5();
    send_syncs(16'h0020, 15);
    cycle(16'h0020);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock5_early got=%b exp=0", locked); end
    cycle('0);
    checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL lock5_locked got=%b exp=1", locked); end
    checks++; if (lane_sel !== 4'd5) begin errors++; $display("FAIL lock5_lane_sel got=%0d exp=5", lane_sel); end
    checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL lock5_valid got=%b exp=1", valid); end
    checks++; if (dataout !== last_word[5]) begin errors++; $display("FAIL lock5_data1 got=%h exp=%h", dataout, last_word[5]); end
    cycle('0);
    checks++; if (dataout !== last_word[5]) begin errors++; $display("FAIL lock5_data2 got=%h exp=%h", dataout, last_word[5]); end
  endtask

  // Continues from test_lock_lane5: word j after the last sync shows up in
  // the status one clock after it is driven.
  task automatic test_gap_unlock();
    int  prev;
    logic exp_err, exp_lock;
    for (int j = 3; j <= 263; j++) begin
      cycle('0);
      prev = j - 1;
      exp_err  = ((prev % 65) == 0) && (prev <= 260);
      exp_lock = (prev < 260);
      checks++; if (sync_err !== exp_err)  begin errors++; $display("FAIL gap_sync_err word=%0d got=%b exp=%b", prev, sync_err, exp_err); end
      checks++; if (locked !== exp_lock)   begin errors++; $display("FAIL gap_locked word=%0d got=%b exp=%b", prev, locked, exp_lock); end
    end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL gap_valid got=%b exp=0", valid); end
    checks++; if (lane_sel !== 4'd0) begin errors++; $display("FAIL gap_lane_sel got=%0d exp=0", lane_sel); end
    checks++; if (dataout !== '0)    begin errors++; $display("FAIL gap_dataout got=%h exp=0000", dataout); end
  endtask

  task automatic test_tie();
    apply_reset();
    send_syncs(16'h0208, 16);
    checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL tie_locked got=%b exp=1", locked); end
    checks++; if (lane_sel !== 4'd3) begin errors++; $display("FAIL tie_lane_sel got=%0d exp=3", lane_sel); end
  endtask

  task automatic test_aging();
    apply_reset();
    send_syncs(16'h0004, 10);
    for (int k = 0; k < 70; k++) cycle('0);
    send_syncs(16'h0004, 6);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL age_stale_lock got=%b exp=0", locked); end
    send_syncs(16'h0004, 10);
    checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL age_locked got=%b exp=1", locked); end
    checks++; if (lane_sel !== 4'd2) begin errors++; $display("FAIL age_lane_sel got=%0d exp=2", lane_sel); end
  endtask

  task automatic test_force_search();
    apply_reset();
    send_syncs(16'h0080, 16);
    checks++; if (lane_sel !== 4'd7) begin errors++; $display("FAIL force_pre_lane got=%0d exp=7", lane_sel); end
    force_search = 1'b1;
    cycle('0);
    force_search = 1'b0;
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL force_unlock got=%b exp=0", locked); end
    checks++; if (lane_sel !== 4'd0) begin errors++; $display("FAIL force_lane_sel got=%0d exp=0", lane_sel); end
    // Force on the very clock the lock decision would be taken.
    send_syncs(16'h0080, 15);
    cycle(16'h0080);
    force_search = 1'b1;
    cycle('0);
    force_search = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL force_priority got=%b exp=0", locked); end
    send_syncs(16'h0080, 15);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL force_cleared got=%b exp=0", locked); end
    send_syncs(16'h0080, 1);
    checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL force_relock got=%b exp=1", locked); end
    checks++; if (lane_sel !== 4'd7) begin errors++; $display("FAIL force_relock_lane got=%0d exp=7", lane_sel); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_syncs(16'h0010, 16);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL arst_pre_lock got=%b exp=1", locked); end
    #2 rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL arst_locked got=%b exp=0", locked); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL arst_valid got=%b exp=0", valid); end
    checks++; if (dataout !== '0)    begin errors++; $display("FAIL arst_dataout got=%h exp=0000", dataout); end
    checks++; if (lane_sel !== 4'd0) begin errors++; $display("FAIL arst_lane_sel got=%0d exp=0", lane_sel); end
    @(posedge clk);
    #1 rst = 1'b0;
    send_syncs(16'h0010, 12);
    #2 rst = 1'b1;
    #1;
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL arst_mid_sync_err got=%b exp=0", sync_err); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL arst_mid_locked got=%b exp=0", locked); end
    @(posedge clk);
    #1 rst = 1'b0;
    send_syncs(16'h0010, 4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_no_carry got=%b exp=0", locked); end
    send_syncs(16'h0010, 12);
    checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL arst_relock got=%b exp=1", locked); end
    checks++; if (lane_sel !== 4'd4) begin errors++; $display("FAIL arst_relock_lane got=%0d exp=4", lane_sel); end
  endtask

  initial begin
    test_reset();
    test_lock_lane5();
    test_gap_unlock();
    test_tie();
    test_aging();
    test_force_search();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
